// File: rtl/arb_pkg.sv
// Shared definitions for the rr_arbiter8 block.
//   NUM_REQ     - number of requesters (fixed at 8)
//   IDX_W       - width of the encoded grant index
//   arb_state_t - arbiter FSM states (ARB_IDLE, ARB_GRANT)
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and rr_arbiter8.
// Handshake: a requester raises its req bit and keeps it up until it sees its
// gnt bit (gnt_vld high); the owner then pulses done for one cycle to release.
// The arbiter never revokes a grant except through the optional hold limit,
// which is flagged by a one-cycle timeout pulse.
//   master : drives en, req, done; observes gnt, gnt_idx, gnt_vld, timeout, state
//   slave  : the arbiter side
//   state  : current FSM state, exported for observation
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               timeout;
    arb_state_t         state;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_vld, timeout, state
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_vld, timeout, state
    );
endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin winner selection.
// Returns the first set req bit found searching upward from ptr, wrapping
// from 7 back to 0, as a one-hot vector plus its binary index.
//   req     in  request vector
//   ptr     in  starting search position
//   win     out one-hot winner (zero when req is zero)
//   win_idx out binary index of the winner (zero when req is zero)
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    always_comb begin : pick
        logic             found;
        logic [IDX_W-1:0] pos;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // 3-bit addition wraps naturally from 7 to 0.
            pos = ptr + IDX_W'(k);
            if (!found && req[pos]) begin
                found    = 1'b1;
                win[pos] = 1'b1;
                win_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered, held grant.
// Optional feature: define RR_ARB_TIMEOUT_EN to revoke a grant held for
// HOLD_MAX cycles without done; otherwise grants are held until done and
// timeout is tied low.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave side of rr_arbiter8_if (en, req, done / gnt, gnt_idx,
//        gnt_vld, timeout, state)
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    if (HOLD_MAX < 2) begin : g_hold_check
        $error("rr_arbiter8: HOLD_MAX must be at least 2");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;

    logic [NUM_REQ-1:0] pick_win;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick8 u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                // done is meaningless without an owner and is ignored here.
                if (bus.en && (|bus.req)) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_win;
                    idx_d   = pick_idx;
                    vld_d   = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                // req and en are deliberately not looked at while an owner holds.
                if (bus.done) begin
                    state_d = ARB_IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
`ifdef RR_ARB_TIMEOUT_EN
                // cnt_q counts completed GRANT cycles; the HOLD_MAX-th ends it.
                else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    state_d = ARB_IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign bus.state   = state_q;
`ifdef RR_ARB_TIMEOUT_EN
    assign bus.timeout = tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural owner/pointer model.
// Honours RR_ARB_TIMEOUT_EN the same way as the design.
module tb_rr_arbiter8;
    import arb_pkg::*;

    localparam int HOLD_MAX = 16;

    logic clk;
    logic rst;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner index (-1 = none), next search start, cycles held, pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_to    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            if (bus.en && bus.req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (m_ptr + k) % 8;
                    if (m_owner < 0 && bus.req[c]) m_owner = c;
                end
                m_hold = 0;
            end
        end else begin
            m_to = 0;
            if (bus.done) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end
`ifdef RR_ARB_TIMEOUT_EN
            else begin
                m_hold++;
                if (m_hold >= HOLD_MAX) begin
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_to    = 1;
                end
            end
`endif
        end
    endtask

    task automatic check_model();
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("gnt",     32'(bus.gnt),     32'(exp_gnt));
        check("gnt_idx", 32'(bus.gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("gnt_vld", 32'(bus.gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
        check("timeout", 32'(bus.timeout), 32'(m_to));
        check("state",   32'(bus.state),   (m_owner >= 0) ? 32'(ARB_GRANT) : 32'(ARB_IDLE));
    endtask

    // One clock: model samples inputs at the edge, outputs checked mid-cycle.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic e, input logic [7:0] r, input logic d);
        bus.en = e; bus.req = r; bus.done = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b0);
        step();
        step();
        check("rst_gnt", 32'(bus.gnt), 32'h00);
        check("rst_vld", 32'(bus.gnt_vld), 32'd0);

        // First grant after reset goes to requester 0.
        rst = 1'b0;
        step();
        check("first_gnt", 32'(bus.gnt), 32'h01);
        check("first_idx", 32'(bus.gnt_idx), 32'd0);

        // Full rotation 1..7,0 with one idle cycle between owners.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'hFF, 1'b1);
            step();
            check("rot_idle", 32'(bus.gnt_vld), 32'd0);
            drive(1'b1, 8'hFF, 1'b0);
            step();
            check("rot_idx", 32'(bus.gnt_idx), 32'(i % 8));
        end

        // Steer ptr to 6: release 0, grant 5, release 5.
        drive(1'b1, 8'h00, 1'b1); step();
        drive(1'b1, 8'h20, 1'b0); step();
        check("grant5", 32'(bus.gnt), 32'h20);
        drive(1'b1, 8'h00, 1'b1); step();
        // ptr=6 with req 0x21: search wraps past 7 to 0.
        drive(1'b1, 8'h21, 1'b0); step();
        check("wrap_gnt", 32'(bus.gnt), 32'h01);
        check("wrap_idx", 32'(bus.gnt_idx), 32'd0);
        drive(1'b1, 8'h20, 1'b1); step();
        drive(1'b1, 8'h20, 1'b0); step();
        check("after_wrap_gnt", 32'(bus.gnt), 32'h20);
        check("after_wrap_idx", 32'(bus.gnt_idx), 32'd5);
        drive(1'b1, 8'h00, 1'b1); step();

        // Owner 3 keeps the grant with its request gone and en low.
        drive(1'b1, 8'h08, 1'b0); step();
        check("own3", 32'(bus.gnt), 32'h08);
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("own3_hold", 32'(bus.gnt), 32'h08);
        end
        drive(1'b0, 8'hFF, 1'b1); step();
        drive(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_low_block", 32'(bus.gnt_vld), 32'd0);
        end

        // Asynchronous reset in the middle of a grant.
        drive(1'b1, 8'hFF, 1'b0); step();
        check("pre_rst_vld", 32'(bus.gnt_vld), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_gnt", 32'(bus.gnt), 32'h00);
        check("async_idx", 32'(bus.gnt_idx), 32'd0);
        check("async_vld", 32'(bus.gnt_vld), 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 8'h00, 1'b0);
        step();

        // Grant to 2 with no done.
        drive(1'b1, 8'h04, 1'b0); step();
        check("own2", 32'(bus.gnt), 32'h04);
        drive(1'b1, 8'h00, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 1; i < HOLD_MAX; i++) begin
            step();
            check("hold_vld", 32'(bus.gnt_vld), 32'd1);
            check("hold_to", 32'(bus.timeout), 32'd0);
        end
        step();
        check("to_pulse", 32'(bus.timeout), 32'd1);
        check("to_vld", 32'(bus.gnt_vld), 32'd0);
        drive(1'b1, 8'hFF, 1'b0); step();
        check("to_single", 32'(bus.timeout), 32'd0);
        check("to_next_idx", 32'(bus.gnt_idx), 32'd3);
        drive(1'b1, 8'h00, 1'b1); step();
`else
        for (int i = 0; i < 3 * HOLD_MAX; i++) begin
            step();
            check("no_to_vld", 32'(bus.gnt_vld), 32'd1);
            check("no_to_pulse", 32'(bus.timeout), 32'd0);
        end
        drive(1'b1, 8'h00, 1'b1); step();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing one downstream resource among eight requesters. It produces a registered one-hot grant plus its 3-bit binary index, using the same bit-i-to-index-i encoding as the team's 8:3 encoder. The grant is held until the owner signals release. It sits in front of any shared datapath slot whose owner must be identified by a 3-bit code.

## Interface
- `NUM_REQ`, 8, number of requesters; fixed at 8 in this revision.
- `IDX_W`, 3, width of the encoded grant index.
- `HOLD_MAX`, 16, maximum cycles a grant may be held; used only when the timeout feature is compiled in.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; gates new grants only.
- `req`  in  8  request vector; bit i is requester i.
- `done`  in  1  release strobe from the current owner.
- `gnt`  out  8  registered one-hot grant; all zero when no owner.
- `gnt_idx`  out  3  binary index of the set `gnt` bit; 0 when no owner.
- `gnt_vld`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine with two states.
  - IDLE: no owner. If `en` and `|req`, choose the winner and go to GRANT.
  - GRANT: owner holds the resource. On `done` go to IDLE.
- Winner selection: first set `req` bit searching upward from `ptr`, wrapping 7 to 0.
  - `ptr` is 3 bits.
  - After each release, `ptr` = (winner + 1) mod 8. Wrap is natural 3-bit overflow.
- While in GRANT:
  - `gnt`, `gnt_idx` and `gnt_vld` are stable.
  - Changes on `req` are ignored, including the owner dropping its request.
  - Deasserting `en` does not revoke the current grant; it only blocks the next grant.
- `done` in IDLE is ignored.
- `gnt_idx` always equals the encoded position of the single `gnt` bit. `gnt` never has more than one bit set.
- Reset values: state IDLE, `ptr`=0, `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_vld`=0, `timeout`=0, hold counter 0.
- Reset mid-grant clears all outputs immediately, without waiting for a clock edge.

## Timing
- Request to grant: `req` sampled at edge N with state IDLE, so `gnt`/`gnt_vld` are high after edge N (1-cycle latency).
- Release: `done` sampled at edge M, so outputs clear after edge M.
  - The earliest next grant samples `req` at edge M+1.
  - There is always one idle cycle between owners.
- Simultaneous requests resolve in the same cycle by rotating priority. Lower-numbered bits do not win by default.
- `done` and the timeout expiry in the same cycle count as a normal release: `timeout` stays 0.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the count reaches `HOLD_MAX` without `done`, the FSM returns to IDLE, `ptr` advances past the owner, and `timeout` pulses high for one cycle, aligned with `gnt_vld` falling.
- Not defined:
  - No counter is implemented.
  - `timeout` is tied to 0.
  - A grant is held indefinitely until `done`.

## Structure
- Shared package `arb_pkg`: `NUM_REQ`, `IDX_W`, and the state enum (`ARB_IDLE`, `ARB_GRANT`).
- One sub-module, `rr_pick8`: purely combinational, takes `req` and `ptr`, and returns the one-hot winner and its 3-bit index.
- The FSM, `ptr` register and hold counter live in `rr_arbiter8`.

## Test plan
- Reset with `req`=8'hFF → all outputs 0. Release reset, `en`=1 → after one edge, `gnt`=8'h01, `gnt_idx`=0.
- `req`=8'hFF held, `done` pulsed after each grant → grants cycle through indices 0,1,…,7,0, each separated by one idle cycle.
- `ptr`=6, `req`=8'h21 → `gnt`=8'h01, `gnt_idx`=0 (wrap). Then `req`=8'h20 → next grant 8'h20, `gnt_idx`=5.
- Owner 3 granted, `req`[3] drops and `en`=0 → grant persists until `done`. Afterwards, no new grant while `en`=0.
- `rst` asserted mid-grant between edges → `gnt`, `gnt_idx`, `gnt_vld` go to 0 without a clock edge.
- With `RR_ARB_TIMEOUT_EN` and `HOLD_MAX`=16, grant to 2 with no `done` → revoked after 16 cycles in GRANT with a single-cycle `timeout` pulse. Next grant starts the search from index 3.
